mips_multicycle_core: RTL and testbench

//  Parametrised multi-cycle MIPS-I subset core: FSM-sequenced datapath, one unified memory port with req/ready handshake.

---
 rtl/mips_pkg.sv | 47 ++++
 rtl/mips_regfile.sv | 28 ++
 rtl/mips_multicycle_core.sv | 199 +++++++++++++++++++
 tb/tb_mips_multicycle_core.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS core: opcodes, functs, ALU control codes,
// the sequencer state type and the ALU itself.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_ctrl_t;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // add/sub wrap silently; slt compares as signed
  function automatic logic [31:0] alu_calc(input alu_ctrl_t ctrl, input logic [31:0] x,
                                           input logic [31:0] y);
    case (ctrl)
      ALU_SUB: return x - y;
      ALU_AND: return x & y;
      ALU_OR:  return x | y;
      ALU_SLT: return {31'd0, $signed(x) < $signed(y)};
      default: return x + y;
    endcase
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port,
// register 0 reads as zero and ignores writes.
module mips_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  input  logic        we,
  input  logic [4:0]  w_addr,
  input  logic [31:0] w_data
);

  logic [31:0] regs [32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (w_addr != 5'd0)) begin
      regs[w_addr] <= w_data;
    end
  end

  assign rs_data = (rs_addr == 5'd0) ? 32'd0 : regs[rs_addr];
  assign rt_data = (rt_addr == 5'd0) ? 32'd0 : regs[rt_addr];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-I subset core: FETCH/DECODE/EXEC/MEM/WB sequencer over a shared datapath,
// one unified memory port, sticky halt and a wrapping retired-instruction counter.
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter int                ADDR_W          = 32,
  parameter logic [ADDR_W-1:0] RESET_PC        = '0,
  parameter int                CNT_W           = 16,
  parameter bit                HALT_ON_ILLEGAL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_out,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic [2:0]        state_dbg
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       ir, a, b, alu_out, mdr;
  logic              retire;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext;
  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign imm_sext = {{16{ir[15]}}, ir[15:0]};

  logic is_r, is_j, is_beq, is_addi, is_lw, is_sw, legal;
  assign is_r    = (opcode == OP_RTYPE);
  assign is_j    = (opcode == OP_J);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_addi = (opcode == OP_ADDI);
  assign is_lw   = (opcode == OP_LW);
  assign is_sw   = (opcode == OP_SW);
  assign legal   = (is_r && (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}))
                 || is_j || is_beq || is_addi || is_lw || is_sw;

  alu_ctrl_t   alu_ctrl;
  logic [31:0] alu_res;
  always_comb begin
    alu_ctrl = ALU_ADD;
    if (is_r) begin
      case (funct)
        FN_SUB:  alu_ctrl = ALU_SUB;
        FN_AND:  alu_ctrl = ALU_AND;
        FN_OR:   alu_ctrl = ALU_OR;
        FN_SLT:  alu_ctrl = ALU_SLT;
        default: alu_ctrl = ALU_ADD;
      endcase
    end
  end
  assign alu_res = alu_calc(alu_ctrl, a, is_r ? b : imm_sext);

  logic mem_aligned;
  assign mem_aligned = (alu_out[1:0] == 2'b00);

  logic [31:0] rf_rs, rf_rt, rf_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  assign rf_we    = (state == S_WB);
  assign rf_waddr = is_r ? rd : rt;
  assign rf_wdata = is_lw ? mdr : alu_out;

  mips_regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .rs_addr (rs),
    .rt_addr (rt),
    .rs_data (rf_rs),
    .rt_data (rf_rt),
    .we      (rf_we),
    .w_addr  (rf_waddr),
    .w_data  (rf_wdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_nxt;
  end

  // j resolves in EXEC alongside beq so both control transfers take three cycles
  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        if (legal) begin
          state_nxt = S_EXEC;
        end else if (HALT_ON_ILLEGAL) begin
          state_nxt = S_HALT;
        end else begin
          state_nxt = S_FETCH;
          retire    = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_j || is_beq) begin
          state_nxt = S_FETCH;
          retire    = 1'b1;
        end else if (is_lw || is_sw) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        if (!mem_aligned) begin
          state_nxt = S_HALT;
        end else if (mem_ready) begin
          state_nxt = is_sw ? S_FETCH : S_WB;
          retire    = is_sw;
        end
      end
      S_WB: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      default: state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      ir          <= '0;
      a           <= '0;
      b           <= '0;
      alu_out     <= '0;
      mdr         <= '0;
      halted      <= 1'b0;
      retired_cnt <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            ir <= mem_rdata;
            pc <= pc + ADDR_W'(4);
          end
        end
        S_DECODE: begin
          a       <= rf_rs;
          b       <= rf_rt;
          alu_out <= 32'(pc) + {imm_sext[29:0], 2'b00};
        end
        S_EXEC: begin
          // beq keeps the branch target computed in DECODE in alu_out
          if (is_j) begin
            pc <= {pc[ADDR_W-1:28], ir[25:0], 2'b00};
          end else if (is_beq) begin
            if (a == b) pc <= ADDR_W'(alu_out);
          end else begin
            alu_out <= alu_res;
          end
        end
        S_MEM: if (mem_aligned && mem_ready) mdr <= mem_rdata;
        default: ;
      endcase
      if (retire) retired_cnt <= retired_cnt + CNT_W'(1);
      if (state_nxt == S_HALT) halted <= 1'b1;
    end
  end

  // Memory handshake: mem_req/mem_we/mem_addr/mem_wdata are held unchanged from assertion
  // until the rising edge where mem_req & mem_ready, which is the transfer; rst low drops them.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst) begin
      if (state == S_FETCH) begin
        mem_req  = 1'b1;
        mem_addr = pc;
      end else if ((state == S_MEM) && mem_aligned) begin
        mem_req   = 1'b1;
        mem_we    = is_sw;
        mem_addr  = ADDR_W'(alu_out);
        mem_wdata = b;
      end
    end
  end

  assign pc_out    = pc;
  assign state_dbg = state;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed programs against a behavioural unified memory; stores are scoreboarded by a monitor,
// retire intervals give per-instruction latency, and a handshake monitor checks stall stability.
module tb_mips_multicycle_core;

  localparam logic [31:0] HALT_INSTR = 32'hFC00_0000;

  logic        clk, rst;
  logic        mem_req, mem_we, mem_ready, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
  logic [3:0]  retired_cnt;
  logic [2:0]  state_dbg;

  logic [31:0] mem [1024];
  int          wait_states, wait_cnt, xfer_cnt;
  int          checks, errors;
  logic [63:0] exp_q[$];
  logic [63:0] exp_st;
  int          lat_q[$];
  int          cyc, last_ret;
  logic [3:0]  last_cnt;
  logic        prev_stall, p_we;
  logic [31:0] p_addr, p_wdata;

  mips_multicycle_core #(
    .ADDR_W          (32),
    .RESET_PC        (32'h0),
    .CNT_W           (4),
    .HALT_ON_ILLEGAL (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .halted      (halted),
    .pc_out      (pc_out),
    .retired_cnt (retired_cnt),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] tgt);
    return {6'h02, tgt};
  endfunction

  // ---------------- memory responder (driver) ----------------
  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    wait_cnt  = 0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (!rst || !mem_req) begin
        wait_cnt = 0;
      end else if (wait_cnt >= wait_states) begin
        mem_ready = 1'b1;
        wait_cnt  = 0;
        xfer_cnt++;
        if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
        else        mem_rdata = mem[mem_addr[11:2]];
      end else begin
        wait_cnt++;
      end
    end
  end

  // ---------------- store scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge clk); #1;
      if (rst && mem_req && mem_we && mem_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL store_unexpected: addr 0x%0h data 0x%0h, no store expected",
                   mem_addr, mem_wdata);
        end else begin
          exp_st = exp_q.pop_front();
          if ({mem_addr, mem_wdata} !== exp_st) begin
            errors++;
            $display("FAIL store: got addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                     mem_addr, mem_wdata, exp_st[63:32], exp_st[31:0]);
          end
        end
      end
    end
  end

  // ---------------- handshake stability / alignment monitor ----------------
  initial begin
    prev_stall = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (prev_stall && rst) begin
        checks++;
        if (!(mem_req && mem_addr == p_addr && mem_we == p_we && mem_wdata == p_wdata)) begin
          errors++;
          $display("FAIL stall_hold: got req %0b addr 0x%0h we %0b, expected req 1 addr 0x%0h we %0b",
                   mem_req, mem_addr, mem_we, p_addr, p_we);
        end
      end
      if (rst && mem_req) begin
        checks++;
        if (mem_addr[1:0] != 2'b00) begin
          errors++;
          $display("FAIL req_align: got addr 0x%0h, expected word aligned", mem_addr);
        end
      end
      prev_stall = rst && mem_req && !mem_ready;
      p_addr     = mem_addr;
      p_we       = mem_we;
      p_wdata    = mem_wdata;
    end
  end

  // ---------------- retire interval recorder ----------------
  initial begin
    forever begin
      @(negedge clk); #1;
      if (!rst) begin
        cyc      = 0;
        last_ret = 0;
        last_cnt = 4'd0;
      end else begin
        cyc++;
        if (retired_cnt != last_cnt) begin
          lat_q.push_back(cyc - last_ret);
          last_ret = cyc;
          last_cnt = retired_cnt;
        end
      end
    end
  end

  // ---------------- helper tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_lat(input string name, input int idx, input int exp);
    check(name, (idx < lat_q.size()) ? 32'(lat_q[idx]) : 32'hFFFF_FFFF, 32'(exp));
  endtask

  task automatic begin_program(input int waits);
    @(negedge clk); #3;
    rst = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = HALT_INSTR;
    exp_q.delete();
    lat_q.delete();
    xfer_cnt    = 0;
    wait_states = waits;
  endtask

  task automatic release_reset();
    @(negedge clk); #3;
    rst = 1'b1;
  endtask

  task automatic wait_halted(input string name, input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    check({name, "_halted"}, 32'(halted), 32'd1);
  endtask

  task automatic wait_retired(input string name, input logic [3:0] target, input int budget);
    int n;
    n = 0;
    while (retired_cnt != target && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    check({name, "_retired"}, 32'(retired_cnt), 32'(target));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    checks      = 0;
    errors      = 0;
    xfer_cnt    = 0;
    rst         = 1'b0;
    wait_states = 100;
    for (int i = 0; i < 1024; i++) mem[i] = HALT_INSTR;

    // reset values, then a stalled first fetch interrupted by reset
    repeat (2) @(negedge clk);
    #2;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_retired", 32'(retired_cnt), 32'd0);
    check("rst_pc", pc_out, 32'd0);
    release_reset();
    repeat (3) @(negedge clk);
    #2;
    check("first_req", 32'(mem_req), 32'd1);
    check("first_addr", mem_addr, 32'h0);
    check("first_we", 32'(mem_we), 32'd0);
    check("stall_pc", pc_out, 32'h0);
    #1;
    rst = 1'b0;
    #1;
    check("rst_drops_req", 32'(mem_req), 32'd0);

    // ALU program, zero-wait memory
    begin_program(0);
    mem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
    mem[2]  = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
    mem[3]  = enc_i(6'h2B, 5'd0, 5'd3, 16'h0040);
    mem[4]  = enc_r(5'd1, 5'd2, 5'd4, 6'h22);
    mem[5]  = enc_i(6'h2B, 5'd0, 5'd4, 16'h0044);
    mem[6]  = enc_r(5'd1, 5'd2, 5'd5, 6'h24);
    mem[7]  = enc_i(6'h2B, 5'd0, 5'd5, 16'h0048);
    mem[8]  = enc_r(5'd1, 5'd2, 5'd6, 6'h25);
    mem[9]  = enc_i(6'h2B, 5'd0, 5'd6, 16'h004C);
    mem[10] = enc_r(5'd4, 5'd1, 5'd7, 6'h2A);
    mem[11] = enc_i(6'h2B, 5'd0, 5'd7, 16'h0050);
    mem[12] = enc_r(5'd1, 5'd4, 5'd8, 6'h2A);
    mem[13] = enc_i(6'h2B, 5'd0, 5'd8, 16'h0054);
    exp_q.push_back({32'h40, 32'd12});
    exp_q.push_back({32'h44, 32'hFFFF_FFFE});
    exp_q.push_back({32'h48, 32'd5});
    exp_q.push_back({32'h4C, 32'd7});
    exp_q.push_back({32'h50, 32'd1});
    exp_q.push_back({32'h54, 32'd0});
    release_reset();
    wait_halted("alu", 200);
    check("alu_retired", 32'(retired_cnt), 32'd14);
    check("alu_pc", pc_out, 32'h3C);
    check("alu_stores_left", 32'(exp_q.size()), 32'd0);
    check_lat("lat_addi", 1, 4);
    check_lat("lat_add", 2, 4);
    check_lat("lat_sw", 3, 4);

    // load with 3 wait states, $0 write discard and $0 read
    begin_program(3);
    mem[0]  = enc_i(6'h23, 5'd0, 5'd1, 16'h0080);
    mem[1]  = enc_i(6'h2B, 5'd0, 5'd1, 16'h0060);
    mem[2]  = enc_r(5'd1, 5'd1, 5'd0, 6'h20);
    mem[3]  = enc_r(5'd0, 5'd0, 5'd4, 6'h20);
    mem[4]  = enc_i(6'h2B, 5'd0, 5'd4, 16'h0064);
    mem[32] = 32'hDEAD_BEEF;
    exp_q.push_back({32'h60, 32'hDEAD_BEEF});
    exp_q.push_back({32'h64, 32'd0});
    release_reset();
    wait_halted("stall", 300);
    check("stall_retired", 32'(retired_cnt), 32'd5);
    check("stall_pc", pc_out, 32'h18);
    check("stall_stores_left", 32'(exp_q.size()), 32'd0);
    check_lat("lat_sw_wait3", 1, 10);
    check_lat("lat_add_wait3", 2, 7);

    // branch not taken, jump, load, store
    begin_program(0);
    mem[0]   = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    mem[1]   = enc_i(6'h04, 5'd1, 5'd0, 16'd5);
    mem[2]   = enc_j(26'h100);
    mem[256] = enc_i(6'h23, 5'd0, 5'd2, 16'h0080);
    mem[257] = enc_i(6'h2B, 5'd0, 5'd2, 16'h0068);
    mem[32]  = 32'h1234_5678;
    exp_q.push_back({32'h68, 32'h1234_5678});
    release_reset();
    wait_halted("branch", 200);
    check("branch_retired", 32'(retired_cnt), 32'd5);
    check("branch_pc", pc_out, 32'h40C);
    check("branch_stores_left", 32'(exp_q.size()), 32'd0);
    check_lat("lat_beq_nt", 1, 3);
    check_lat("lat_j", 2, 3);
    check_lat("lat_lw", 3, 5);
    check_lat("lat_sw_after_lw", 4, 4);

    // beq $0,$0,-1 loops on itself
    begin_program(0);
    mem[0] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);
    release_reset();
    wait_retired("loop", 4'd3, 60);
    check("loop_pc", pc_out, 32'h0);
    check("loop_not_halted", 32'(halted), 32'd0);
    check_lat("lat_beq_t1", 1, 3);
    check_lat("lat_beq_t2", 2, 3);

    // misaligned load halts without a data request
    begin_program(0);
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'h0040);
    mem[1] = enc_i(6'h23, 5'd1, 5'd2, 16'd2);
    release_reset();
    wait_halted("misalign", 100);
    repeat (3) @(negedge clk);
    #2;
    check("misalign_retired", 32'(retired_cnt), 32'd1);
    check("misalign_pc", pc_out, 32'h8);
    check("misalign_xfers", 32'(xfer_cnt), 32'd2);
    check("misalign_req_low", 32'(mem_req), 32'd0);

    // illegal funct halts; the following store must never happen
    begin_program(0);
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    mem[1] = enc_r(5'd1, 5'd1, 5'd2, 6'h3F);
    mem[2] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0070);
    release_reset();
    wait_halted("illegal_fn", 100);
    repeat (4) @(negedge clk);
    #2;
    check("illegal_fn_retired", 32'(retired_cnt), 32'd1);
    check("illegal_fn_pc", pc_out, 32'h8);

    // 17 instructions wrap the 4-bit retire counter to 1
    begin_program(0);
    for (int i = 0; i < 16; i++) mem[i] = enc_i(6'h08, 5'd1, 5'd1, 16'd1);
    mem[16] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0070);
    exp_q.push_back({32'h70, 32'd16});
    release_reset();
    wait_halted("wrap", 300);
    check("wrap_retired", 32'(retired_cnt), 32'd1);
    check("wrap_pc", pc_out, 32'h48);
    check("wrap_stores_left", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
